controller_sequencer: RTL and testbench
=======================================

CONTROLLER_SEQUENCER -- requirements
Module: controller_sequencer

Interface
REQ-001 Ports SHALL be exactly: clk, clear, opcode, con, t_state, hlt; plus instr_count when INSTR_COUNT_EN is defined.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 clear  input  1  reset; asynchronous, active-high.
REQ-004 opcode  input  4  instruction-register upper nibble; valid during T4-T6.
REQ-005 con  output  12  control word, bit11..0 = Cp Ep Lm_n CE_n Li_n Ei_n La_n Ea Su Eu Lb_n Lo_n.
REQ-006 t_state  output  6  one-hot ring state; bit0 = T1 ... bit5 = T6.
REQ-007 hlt  output  1  registered halt flag; high = sequencer stopped.

Function
REQ-008 The ring counter SHALL advance T1->T2->...->T6->T1 by one position per posedge clk while not halted.
REQ-009 t_state SHALL always be exactly one-hot; any non-one-hot value SHALL reload T1 on the next edge.
REQ-010 con SHALL be combinational from t_state, opcode and hlt, with zero latency.
REQ-011 Idle word SHALL be 0x3E3 (all signals inactive).
REQ-012 Fetch SHALL be independent of opcode: T1 = 0x5E3, T2 = 0xBE3, T3 = 0x263.
REQ-013 LDA (0000) SHALL drive T4 0x1A3, T5 0x2C3, T6 0x3E3.
REQ-014 ADD (0001) SHALL drive T4 0x1A3, T5 0x2E1, T6 0x3C7.
REQ-015 SUB (0010) SHALL drive T4 0x1A3, T5 0x2E1, T6 0x3CF.
REQ-016 OUT (1110) SHALL drive T4 0x3F2, T5 0x3E3, T6 0x3E3.
REQ-017 Any other opcode except HLT SHALL drive 0x3E3 in T4-T6, i.e. execute as NOP.
REQ-018 HLT (1111) in T4:
- con = 0x3E3 during T4.
- The next posedge SHALL set hlt and hold t_state at T4 (no advance).
REQ-019 While hlt=1:
- t_state SHALL stay frozen.
- con SHALL be 0x3E3 regardless of opcode changes.
- Only clear SHALL exit the halted state.
REQ-020 Opcode changes during T1-T3 SHALL NOT affect con.

Reset
REQ-021 clear high SHALL immediately, without waiting for clk, force t_state=000001, hlt=0 and instr_count=0.
REQ-022 During and after reset, con SHALL equal 0x5E3; the first posedge after clear falls SHALL move to T2.
REQ-023 Asserting clear mid-instruction or while halted SHALL abort the instruction and restart at T1 with no residual state.

Configuration
REQ-024 Macro INSTR_COUNT_EN SHALL control the instruction counter.
- Defined: add output instr_count (8 bits), incremented on each posedge leaving T6, wrapping 255->0, never incremented while halted.
- Undefined: port and logic absent; all other behaviour identical.

Verification
REQ-025 Reset: assert clear mid-T5 with no clock edge -> t_state=000001, con=0x5E3, hlt=0 in the same timestep.
REQ-026 LDA: opcode=0000 over 6 clocks -> con sequence 5E3, BE3, 263, 1A3, 2C3, 3E3, then back to T1.
REQ-027 ADD then SUB: T6 shows 0x3C7 for ADD and 0x3CF for SUB; OUT T4 shows 0x3F2.
REQ-028 HLT: opcode=1111 at T4 -> after the edge hlt=1, t_state=001000 for 10+ clocks, con=0x3E3 while opcode toggles; clear pulse -> T1, hlt=0.
REQ-029 NOP and fetch isolation:
- opcode=0101 -> T4-T6 = 0x3E3.
- Toggling opcode during T1-T3 -> fetch words unchanged.
REQ-030 INSTR_COUNT_EN: 256 full LDA cycles -> instr_count wraps to 0; with the macro undefined, the build elaborates without the port.

Source files
------------

// File: rtl/controller_sequencer.sv
// Six-phase ring-counter sequencer producing the 12-bit control word for a SAP-1 style CPU.
// Optional instruction counter output is enabled by defining INSTR_COUNT_EN.
module controller_sequencer (
    input  logic        clk,
    input  logic        clear,
    input  logic [3:0]  opcode,
    output logic [11:0] con,
    output logic [5:0]  t_state,
    output logic        hlt
`ifdef INSTR_COUNT_EN
    ,
    output logic [7:0]  instr_count
`endif
);

    typedef enum logic [5:0] {
        T1 = 6'b000001,
        T2 = 6'b000010,
        T3 = 6'b000100,
        T4 = 6'b001000,
        T5 = 6'b010000,
        T6 = 6'b100000
    } ring_t;

    typedef enum logic [3:0] {
        OP_LDA = 4'b0000,
        OP_ADD = 4'b0001,
        OP_SUB = 4'b0010,
        OP_OUT = 4'b1110,
        OP_HLT = 4'b1111
    } op_t;

    // Control word bit order: Cp Ep Lm_n CE_n Li_n Ei_n La_n Ea Su Eu Lb_n Lo_n.
    localparam logic [11:0] CON_IDLE   = 12'h3E3;
    localparam logic [11:0] CON_FETCH1 = 12'h5E3;
    localparam logic [11:0] CON_FETCH2 = 12'hBE3;
    localparam logic [11:0] CON_FETCH3 = 12'h263;
    localparam logic [11:0] CON_MAR_IR = 12'h1A3;
    localparam logic [11:0] CON_LDA_T5 = 12'h2C3;
    localparam logic [11:0] CON_ALU_T5 = 12'h2E1;
    localparam logic [11:0] CON_ADD_T6 = 12'h3C7;
    localparam logic [11:0] CON_SUB_T6 = 12'h3CF;
    localparam logic [11:0] CON_OUT_T4 = 12'h3F2;

    ring_t ring_q;
    ring_t ring_d;
    logic  ring_valid;
    logic  hlt_d;

    // NOTE: every variable written here gets a default first so no latch is inferred.
    always_comb begin
        ring_d     = T1;
        ring_valid = 1'b1;
        hlt_d      = hlt;
        case (ring_q)
            T1: ring_d = T2;
            T2: ring_d = T3;
            T3: ring_d = T4;
            T4: ring_d = (opcode == OP_HLT) ? T4 : T5;
            T5: ring_d = T6;
            T6: ring_d = T1;
            default: begin
                ring_d     = T1;
                ring_valid = 1'b0;
            end
        endcase

        // A halted ring holds position; a corrupted ring always reloads T1.
        if (hlt && ring_valid) begin
            ring_d = ring_q;
        end

        if (!hlt && ring_q == T4 && opcode == OP_HLT) begin
            hlt_d = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            ring_q <= T1;
            hlt    <= 1'b0;
        end else begin
            ring_q <= ring_d;
            hlt    <= hlt_d;
        end
    end

    assign t_state = ring_q;

    always_comb begin
        con = CON_IDLE;
        if (!hlt) begin
            case (ring_q)
                T1: con = CON_FETCH1;
                T2: con = CON_FETCH2;
                T3: con = CON_FETCH3;
                T4: begin
                    case (opcode)
                        OP_LDA, OP_ADD, OP_SUB: con = CON_MAR_IR;
                        OP_OUT:                 con = CON_OUT_T4;
                        default:                con = CON_IDLE;
                    endcase
                end
                T5: begin
                    case (opcode)
                        OP_LDA:         con = CON_LDA_T5;
                        OP_ADD, OP_SUB: con = CON_ALU_T5;
                        default:        con = CON_IDLE;
                    endcase
                end
                T6: begin
                    case (opcode)
                        OP_ADD:  con = CON_ADD_T6;
                        OP_SUB:  con = CON_SUB_T6;
                        default: con = CON_IDLE;
                    endcase
                end
                default: con = CON_IDLE;
            endcase
        end
    end

`ifdef INSTR_COUNT_EN
    // Counts completed instructions; T6 can never be the halted position.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            instr_count <= 8'd0;
        end else if (!hlt && ring_q == T6) begin
            instr_count <= instr_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_controller_sequencer.sv
// Directed, table-driven bench for controller_sequencer; define INSTR_COUNT_EN to also
// exercise the instruction counter.
module tb_controller_sequencer;

    logic        clk;
    logic        clear;
    logic [3:0]  opcode;
    logic [11:0] con;
    logic [5:0]  t_state;
    logic        hlt;
`ifdef INSTR_COUNT_EN
    logic [7:0]  instr_count;
`endif

    int n_checks = 0;
    int n_bad    = 0;

    controller_sequencer dut (
        .clk     (clk),
        .clear   (clear),
        .opcode  (opcode),
        .con     (con),
        .t_state (t_state),
        .hlt     (hlt)
`ifdef INSTR_COUNT_EN
        ,
        .instr_count (instr_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [5:0]  t;
        logic [11:0] con;
        logic        hlt;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic [3:0] op, input logic [5:0] t, input logic [11:0] c,
                           input logic h);
        vec_t v;
        v.op  = op;
        v.t   = t;
        v.con = c;
        v.hlt = h;
        vecs.push_back(v);
    endtask

    // Fetch words for one instruction, with a chosen opcode presented during each fetch phase.
    task automatic add_fetch(input logic [3:0] o1, input logic [3:0] o2, input logic [3:0] o3);
        add_vec(o1, 6'b000001, 12'h5E3, 1'b0);
        add_vec(o2, 6'b000010, 12'hBE3, 1'b0);
        add_vec(o3, 6'b000100, 12'h263, 1'b0);
    endtask

    task automatic check_all(input string tag, input logic [5:0] t, input logic [11:0] c,
                             input logic h);
        check({tag, ".t_state"}, 32'(t_state), 32'(t));
        check({tag, ".con"}, 32'(con), 32'(c));
        check({tag, ".hlt"}, 32'(hlt), 32'(h));
    endtask

    initial begin
        clear  = 1'b1;
        opcode = 4'h0;
        #1;
        check_all("reset_async", 6'b000001, 12'h5E3, 1'b0);
        @(posedge clk);
        #1;
        check_all("reset_held_over_edge", 6'b000001, 12'h5E3, 1'b0);
        @(negedge clk);
        clear = 1'b0;

        // LDA, ADD, SUB, OUT, then NOP with opcode churning during fetch.
        add_fetch(4'h0, 4'h0, 4'h0);
        add_vec(4'h0, 6'b001000, 12'h1A3, 1'b0);
        add_vec(4'h0, 6'b010000, 12'h2C3, 1'b0);
        add_vec(4'h0, 6'b100000, 12'h3E3, 1'b0);
        add_fetch(4'h1, 4'h1, 4'h1);
        add_vec(4'h1, 6'b001000, 12'h1A3, 1'b0);
        add_vec(4'h1, 6'b010000, 12'h2E1, 1'b0);
        add_vec(4'h1, 6'b100000, 12'h3C7, 1'b0);
        add_fetch(4'h2, 4'h2, 4'h2);
        add_vec(4'h2, 6'b001000, 12'h1A3, 1'b0);
        add_vec(4'h2, 6'b010000, 12'h2E1, 1'b0);
        add_vec(4'h2, 6'b100000, 12'h3CF, 1'b0);
        add_fetch(4'hE, 4'hE, 4'hE);
        add_vec(4'hE, 6'b001000, 12'h3F2, 1'b0);
        add_vec(4'hE, 6'b010000, 12'h3E3, 1'b0);
        add_vec(4'hE, 6'b100000, 12'h3E3, 1'b0);
        add_fetch(4'hF, 4'hE, 4'h1);
        add_vec(4'h5, 6'b001000, 12'h3E3, 1'b0);
        add_vec(4'h5, 6'b010000, 12'h3E3, 1'b0);
        add_vec(4'h5, 6'b100000, 12'h3E3, 1'b0);
        // HLT instruction: T4 stays idle, then the ring freezes.
        add_fetch(4'h3, 4'h3, 4'h3);
        add_vec(4'hF, 6'b001000, 12'h3E3, 1'b0);

        foreach (vecs[i]) begin
            opcode = vecs[i].op;
            #1;
            check_all($sformatf("vec%0d", i), vecs[i].t, vecs[i].con, vecs[i].hlt);
            @(negedge clk);
        end

        // Halted: ring frozen at T4, idle word, opcode churn ignored.
        for (int k = 0; k < 12; k++) begin
            opcode = 4'(k * 5 + 1);
            #1;
            check_all($sformatf("halt%0d", k), 6'b001000, 12'h3E3, 1'b1);
            @(negedge clk);
        end

        // Clear pulse exits halt immediately.
        #2;
        clear = 1'b1;
        #1;
        check_all("halt_clear", 6'b000001, 12'h5E3, 1'b0);
        @(negedge clk);
        clear  = 1'b0;
        opcode = 4'h0;
        #1;
        check_all("after_clear_t1", 6'b000001, 12'h5E3, 1'b0);
        @(negedge clk);
        #1;
        check_all("after_clear_t2", 6'b000010, 12'hBE3, 1'b0);

        // Abort mid-T5 with no clock edge.
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        #1;
        check_all("pre_abort_t5", 6'b010000, 12'h2C3, 1'b0);
        #1;
        clear = 1'b1;
        #1;
        check_all("abort_mid_t5", 6'b000001, 12'h5E3, 1'b0);
        @(negedge clk);
        clear = 1'b0;
        #1;
        check_all("abort_release", 6'b000001, 12'h5E3, 1'b0);

`ifdef INSTR_COUNT_EN
        check("count_reset", 32'(instr_count), 32'd0);
        opcode = 4'h0;
        for (int n = 1; n <= 256; n++) begin
            repeat (6) @(negedge clk);
            if (n == 1 || n == 2 || n == 255 || n == 256) begin
                check($sformatf("count_after_%0d", n), 32'(instr_count), 32'(n % 256));
                check($sformatf("count_ring_%0d", n), 32'(t_state), 32'h1);
            end
        end
        // A halted instruction never reaches T6, so the count must stay put.
        repeat (3) @(negedge clk);
        opcode = 4'hF;
        repeat (8) @(negedge clk);
        #1;
        check("count_halted_hlt", 32'(hlt), 32'd1);
        check("count_halted", 32'(instr_count), 32'd0);
        clear = 1'b1;
        #1;
        check("count_clear", 32'(instr_count), 32'd0);
        clear = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
